// File: rtl/neighbor_table_update.sv
// rtl/neighbor_table_update.sv - neighbor table insert/update engine with known-cluster-head tracking
//
// Purpose: for each accepted packet, search the external neighbor table for the
// packet source. A hit rewrites that entry and a miss appends a new entry (or
// drops the packet when the table is full). A cluster-head announcement also
// registers its source in a small internal known-CH list.
//
// Ports:
//   clock, nrst          - rising-edge clock, asynchronous active-low reset
//   en                   - packet strobe, sampled only in IDLE
//   fSourceID..fQValue   - packet fields; packetType selects a CH announcement
//   rd_addr / mSourceID  - table read port (data arrives one cycle after the address)
//   wr_en, wr_addr       - table write strobe and address
//   nodeID..nodeQValue   - table write data (the latched packet fields)
//   neighborCount        - number of valid table entries
//   knownCHCount, chID   - known-CH list fill level and most recently added CH
//   busy, done           - engine active / one-cycle completion pulse
//   found, dropped       - packet outcome, valid while done is high
//   chFull               - known-CH list is full
module neighbor_table_update #(
  parameter int         WORD_WIDTH    = 16,
  parameter int         MAX_NEIGHBORS = 32,
  parameter int         ADDR_WIDTH    = 5,
  parameter int         MAX_CH        = 8,
  parameter logic [2:0] CH_PKT        = 3'd2
) (
  input  logic                           clock,
  input  logic                           nrst,
  input  logic                           en,
  input  logic [WORD_WIDTH-1:0]          fSourceID,
  input  logic [WORD_WIDTH-1:0]          fClusterID,
  input  logic [WORD_WIDTH-1:0]          fEnergyLeft,
  input  logic [WORD_WIDTH-1:0]          fQValue,
  input  logic [2:0]                     packetType,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic [WORD_WIDTH-1:0]          mSourceID,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [WORD_WIDTH-1:0]          nodeID,
  output logic [WORD_WIDTH-1:0]          nodeClusterID,
  output logic [WORD_WIDTH-1:0]          nodeEnergy,
  output logic [WORD_WIDTH-1:0]          nodeQValue,
  output logic [ADDR_WIDTH:0]            neighborCount,
  output logic [$clog2(MAX_CH+1)-1:0]    knownCHCount,
  output logic [WORD_WIDTH-1:0]          chID,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic                           dropped,
  output logic                           chFull
);

  localparam int CW = $clog2(MAX_CH + 1);
  localparam int KW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

  localparam logic [ADDR_WIDTH:0] NB_MAX = (ADDR_WIDTH + 1)'(MAX_NEIGHBORS);
  localparam logic [ADDR_WIDTH:0] NB_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [CW-1:0]       CH_MAX = CW'(MAX_CH);
  localparam logic [CW-1:0]       CH_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_COMPARE, S_ADD, S_UPDATE, S_CHSCAN, S_CHADD, S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] n;
  logic [CW-1:0]         k;
  logic [2:0]            pkt_type;
  logic [WORD_WIDTH-1:0] ch_list [MAX_CH];

  logic [ADDR_WIDTH:0]   n_next;
  logic                  table_room;
  logic                  ch_hit;

  // n_next is one bit wider than n so the end-of-table test cannot alias.
  assign n_next     = {1'b0, n} + NB_ONE;
  assign table_room = (neighborCount < NB_MAX);
  assign ch_hit     = (ch_list[k[KW-1:0]] == nodeID);
  assign chFull     = (knownCHCount == CH_MAX);

  // The node* registers double as the packet latch: they are loaded once when
  // the packet is accepted, so they already hold the write data in UPDATE/ADD.
  // wr_en and wr_addr are loaded on entry to UPDATE/ADD so that the registered
  // strobe is high exactly during that state.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state         <= S_IDLE;
      n             <= '0;
      k             <= '0;
      pkt_type      <= '0;
      rd_addr       <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      nodeID        <= '0;
      nodeClusterID <= '0;
      nodeEnergy    <= '0;
      nodeQValue    <= '0;
      neighborCount <= '0;
      knownCHCount  <= '0;
      chID          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      dropped       <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) ch_list[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            nodeID        <= fSourceID;
            nodeClusterID <= fClusterID;
            nodeEnergy    <= fEnergyLeft;
            nodeQValue    <= fQValue;
            pkt_type      <= packetType;
            n             <= '0;
            k             <= '0;
            found         <= 1'b0;
            dropped       <= 1'b0;
            busy          <= 1'b1;
            if (neighborCount != '0) begin
              rd_addr <= '0;
              state   <= S_READ;
            end else begin
              // Empty table always has room for the first entry.
              wr_en   <= 1'b1;
              wr_addr <= '0;
              state   <= S_ADD;
            end
          end
        end
        S_READ: state <= S_COMPARE;
        S_COMPARE: begin
          if (mSourceID == nodeID) begin
            wr_en   <= 1'b1;
            wr_addr <= n;
            state   <= S_UPDATE;
          end else if (n_next < neighborCount) begin
            n       <= n_next[ADDR_WIDTH-1:0];
            rd_addr <= n_next[ADDR_WIDTH-1:0];
            state   <= S_READ;
          end else begin
            wr_en   <= table_room;
            wr_addr <= neighborCount[ADDR_WIDTH-1:0];
            state   <= S_ADD;
          end
        end
        S_UPDATE, S_ADD: begin
          wr_en <= 1'b0;
          if (state == S_UPDATE) found <= 1'b1;
          else if (table_room) neighborCount <= neighborCount + NB_ONE;
          else dropped <= 1'b1;
          if (pkt_type == CH_PKT) begin
            state <= S_CHSCAN;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_CHSCAN: begin
          // End-of-list is tested first so the lookup never uses a stale entry.
          if (k == knownCHCount) begin
            state <= S_CHADD;
          end else if (ch_hit) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            k <= k + CH_ONE;
          end
        end
        S_CHADD: begin
          if (!chFull) begin
            ch_list[knownCHCount[KW-1:0]] <= nodeID;
            knownCHCount                  <= knownCHCount + CH_ONE;
            chID                          <= nodeID;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_table_update.sv
// tb/tb_neighbor_table_update.sv - self-checking bench for neighbor_table_update
module tb_neighbor_table_update;

  localparam int         W    = 16;
  localparam int         AW   = 5;
  localparam int         NMAX = 32;
  localparam int         CMAX = 8;
  localparam logic [2:0] CHP  = 3'd2;

  logic          clock = 1'b0;
  logic          nrst  = 1'b0;
  logic          en    = 1'b0;
  logic [W-1:0]  fSourceID = '0, fClusterID = '0, fEnergyLeft = '0, fQValue = '0;
  logic [2:0]    packetType = '0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  mSourceID;
  logic          wr_en;
  logic [W-1:0]  nodeID, nodeClusterID, nodeEnergy, nodeQValue, chID;
  logic [AW:0]   neighborCount;
  logic [3:0]    knownCHCount;
  logic          busy, done, found, dropped, chFull;

  neighbor_table_update dut (
    .clock(clock), .nrst(nrst), .en(en),
    .fSourceID(fSourceID), .fClusterID(fClusterID), .fEnergyLeft(fEnergyLeft),
    .fQValue(fQValue), .packetType(packetType),
    .rd_addr(rd_addr), .mSourceID(mSourceID),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .nodeID(nodeID), .nodeClusterID(nodeClusterID), .nodeEnergy(nodeEnergy),
    .nodeQValue(nodeQValue), .neighborCount(neighborCount),
    .knownCHCount(knownCHCount), .chID(chID), .busy(busy), .done(done),
    .found(found), .dropped(dropped), .chFull(chFull)
  );

  always #5 clock = ~clock;

  // External table RAM with a one-cycle read latency.
  logic [W-1:0] mem [NMAX];
  always @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= nodeID;
    mSourceID <= mem[rd_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: list of stored IDs and list of known CHs.
  logic [W-1:0] ref_ids [NMAX];
  int           ref_n    = 0;
  logic [W-1:0] ref_ch  [CMAX];
  int           ref_k    = 0;
  logic [W-1:0] ref_chid = '0;

  int            got_lat;
  logic          got_found, got_dropped;
  int            wr_cnt;
  logic [AW-1:0] cap_addr;
  logic [W-1:0]  cap_id, cap_cid, cap_eng, cap_q;

  typedef struct {
    logic [W-1:0] src;
    logic [W-1:0] q;
    logic [2:0]   pt;
    logic         ef;
    int           ecnt;
    int           elat;
    int           ewa;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] src, input logic [W-1:0] cid, input logic [W-1:0] eng,
                      input logic [W-1:0] q, input logic [2:0] pt, input bit inject);
    en = 1'b1; fSourceID = src; fClusterID = cid; fEnergyLeft = eng; fQValue = q; packetType = pt;
    @(negedge clock);
    en = 1'b0;
    fSourceID = W'($urandom); fClusterID = W'($urandom);
    fEnergyLeft = W'($urandom); fQValue = W'($urandom); packetType = 3'($urandom);
    got_lat = -1; wr_cnt = 0; got_found = 1'b0; got_dropped = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (inject && c == 1) begin en = 1'b1; fSourceID = 16'h0022; packetType = CHP; end
      if (inject && c == 2) en = 1'b0;
      if (c == 1) chk("busy_during_pkt", 32'(busy), 32'd1);
      if (wr_en) begin
        wr_cnt++;
        cap_addr = wr_addr; cap_id = nodeID; cap_cid = nodeClusterID;
        cap_eng = nodeEnergy; cap_q = nodeQValue;
      end
      if (done) begin
        got_lat = c; got_found = found; got_dropped = dropped;
        break;
      end
      @(negedge clock);
    end
    en = 1'b0;
    if (got_lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done within 200 cycles, required done");
    end
    @(negedge clock);
  endtask

  task automatic run_pkt(input logic [W-1:0] src, input logic [W-1:0] cid, input logic [W-1:0] eng,
                         input logic [W-1:0] q, input logic [2:0] pt, input bit inject);
    int idx, j, elat;
    bit lat_ok, ewr, edrop;
    logic [AW-1:0] ewa;
    idx = -1; j = -1; lat_ok = 1; ewr = 1; edrop = 0; ewa = '0;
    for (int i = 0; i < ref_n; i++) if (idx < 0 && ref_ids[i] == src) idx = i;
    if (idx >= 0) begin
      elat = 2 * (idx + 1) + 2;
      ewa  = AW'(idx);
    end else begin
      elat = 2 * ref_n + 2;
      if (ref_n < NMAX) begin
        ewa = AW'(ref_n); ref_ids[ref_n] = src; ref_n++;
      end else begin
        ewr = 0; edrop = 1;
      end
    end
    if (pt == CHP) begin
      for (int i = 0; i < ref_k; i++) if (j < 0 && ref_ch[i] == src) j = i;
      if (j >= 0) lat_ok = 0;
      else begin
        elat += ref_k + 2;
        if (ref_k < CMAX) begin ref_ch[ref_k] = src; ref_k++; ref_chid = src; end
      end
    end
    send(src, cid, eng, q, pt, inject);
    if (lat_ok) chk($sformatf("latency id=%0h", src), 32'(got_lat), 32'(elat));
    chk($sformatf("found id=%0h", src), 32'(got_found), 32'(idx >= 0));
    chk($sformatf("dropped id=%0h", src), 32'(got_dropped), 32'(edrop));
    chk($sformatf("wr_count id=%0h", src), 32'(wr_cnt), 32'(ewr));
    if (ewr) begin
      chk("wr_addr", 32'(cap_addr), 32'(ewa));
      chk("nodeID", 32'(cap_id), 32'(src));
      chk("nodeClusterID", 32'(cap_cid), 32'(cid));
      chk("nodeEnergy", 32'(cap_eng), 32'(eng));
      chk("nodeQValue", 32'(cap_q), 32'(q));
    end
    chk("neighborCount", 32'(neighborCount), 32'(ref_n));
    chk("knownCHCount", 32'(knownCHCount), 32'(ref_k));
    chk("chID", 32'(chID), 32'(ref_chid));
    chk("chFull", 32'(chFull), 32'(ref_k == CMAX));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen_done, seen_wr;
    vecs[0] = '{src: 16'h0003, q: 16'h0001, pt: 3'd0, ef: 1'b0, ecnt: 1, elat: 2,  ewa: 0};
    vecs[1] = '{src: 16'h0005, q: 16'h0002, pt: 3'd0, ef: 1'b0, ecnt: 2, elat: 4,  ewa: 1};
    vecs[2] = '{src: 16'h0009, q: 16'h0003, pt: 3'd0, ef: 1'b0, ecnt: 3, elat: 6,  ewa: 2};
    vecs[3] = '{src: 16'h0009, q: 16'h0040, pt: 3'd0, ef: 1'b1, ecnt: 3, elat: 8,  ewa: 2};
    vecs[4] = '{src: 16'h0005, q: 16'h0007, pt: 3'd0, ef: 1'b1, ecnt: 3, elat: 6,  ewa: 1};
    vecs[5] = '{src: 16'h0100, q: 16'h0008, pt: CHP,  ef: 1'b0, ecnt: 4, elat: 10, ewa: 3};

    nrst = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst nodeID", 32'(nodeID), 32'd0);
    chk("rst nodeQValue", 32'(nodeQValue), 32'd0);
    chk("rst neighborCount", 32'(neighborCount), 32'd0);
    chk("rst knownCHCount", 32'(knownCHCount), 32'd0);
    chk("rst chID", 32'(chID), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst found", 32'(found), 32'd0);
    chk("rst dropped", 32'(dropped), 32'd0);
    chk("rst chFull", 32'(chFull), 32'd0);
    nrst = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 6; v++) begin
      run_pkt(vecs[v].src, 16'h0A00 + 16'(v), 16'h0B00 + 16'(v), vecs[v].q, vecs[v].pt, 1'b0);
      chk($sformatf("vec%0d lat", v), 32'(got_lat), 32'(vecs[v].elat));
      chk($sformatf("vec%0d found", v), 32'(got_found), 32'(vecs[v].ef));
      chk($sformatf("vec%0d count", v), 32'(neighborCount), 32'(vecs[v].ecnt));
      chk($sformatf("vec%0d wr_addr", v), 32'(cap_addr), 32'(vecs[v].ewa));
    end

    // Reset while the first COMPARE is in progress.
    en = 1'b1; fSourceID = 16'h0077; packetType = 3'd0;
    @(negedge clock);
    en = 1'b0;
    @(negedge clock);
    chk("midrst busy_before", 32'(busy), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst neighborCount", 32'(neighborCount), 32'd0);
    chk("midrst knownCHCount", 32'(knownCHCount), 32'd0);
    chk("midrst chID", 32'(chID), 32'd0);
    chk("midrst rd_addr", 32'(rd_addr), 32'd0);
    chk("midrst nodeID", 32'(nodeID), 32'd0);
    @(negedge clock);
    nrst = 1'b1;
    ref_n = 0; ref_k = 0; ref_chid = '0;
    seen_done = 0; seen_wr = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) seen_done++;
      if (wr_en) seen_wr++;
    end
    chk("midrst no_done", 32'(seen_done), 32'd0);
    chk("midrst no_write", 32'(seen_wr), 32'd0);

    // First packet into an empty table.
    run_pkt(16'h0005, 16'h0001, 16'h0002, 16'h0003, 3'd0, 1'b0);
    chk("empty lat", 32'(got_lat), 32'd2);
    chk("empty wr_addr", 32'(cap_addr), 32'd0);
    chk("empty found", 32'(got_found), 32'd0);
    chk("empty count", 32'(neighborCount), 32'd1);

    // en pulsed while busy must be ignored.
    run_pkt(16'h0011, 16'h0004, 16'h0005, 16'h0006, 3'd0, 1'b1);
    repeat (5) @(negedge clock);
    chk("busy_en ignored busy", 32'(busy), 32'd0);
    chk("busy_en ignored count", 32'(neighborCount), 32'd2);

    // Fill the known-CH list past capacity, then repeat a known CH.
    for (int i = 0; i < 9; i++)
      run_pkt(16'h0300 + 16'(i), 16'h0C00, 16'h0D00, 16'h0E00 + 16'(i), CHP, 1'b0);
    chk("chfill count", 32'(knownCHCount), 32'd8);
    chk("chfill full", 32'(chFull), 32'd1);
    chk("chfill chID", 32'(chID), 32'h0307);
    run_pkt(16'h0303, 16'h0C01, 16'h0D01, 16'h0E01, CHP, 1'b0);
    chk("ch repeat count", 32'(knownCHCount), 32'd8);

    repeat (60)
      run_pkt(16'($urandom_range(1, 40)), W'($urandom), W'($urandom), W'($urandom),
              3'($urandom_range(0, 3)), 1'b0);

    while (ref_n < NMAX)
      run_pkt(16'h1000 + 16'(ref_n), 16'h0001, 16'h0002, 16'h0003, 3'd0, 1'b0);
    run_pkt(16'h2000, 16'h0001, 16'h0002, 16'h0003, 3'd0, 1'b0);
    chk("full dropped", 32'(got_dropped), 32'd1);
    chk("full no_write", 32'(wr_cnt), 32'd0);
    chk("full count", 32'(neighborCount), 32'd32);
    chk("full lat", 32'(got_lat), 32'd66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/neighbor_table_update.md
NEIGHBOR_TABLE_UPDATE -- requirements
Module: neighbor_table_update

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, width of IDs, energy and Q-value fields.
REQ-002 SHALL have parameter MAX_NEIGHBORS, default 32, neighbor table depth.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, neighbor table address width; MAX_NEIGHBORS <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter MAX_CH, default 8, depth of the internal known-cluster-head list.
REQ-005 SHALL have parameter CH_PKT, default 3'd2, packetType value marking a cluster-head announcement.
REQ-006 SHALL have ports (name  direction  width  meaning):
- clock  in  1  single clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- en  in  1  new packet strobe; f* inputs and packetType are valid in this cycle.
- fSourceID, fClusterID, fEnergyLeft, fQValue  in  WORD_WIDTH each  packet fields.
- packetType  in  3  packet type.
- rd_addr  out  ADDR_WIDTH  neighbor table read address.
- mSourceID  in  WORD_WIDTH  table read data, valid one cycle after rd_addr.
- wr_en  out  1  table write strobe.
- wr_addr  out  ADDR_WIDTH  table write address.
- nodeID, nodeClusterID, nodeEnergy, nodeQValue  out  WORD_WIDTH each  table write data.
- neighborCount  out  ADDR_WIDTH+1  valid entries.
- knownCHCount  out  $clog2(MAX_CH+1)  valid known-CH entries.
- chID  out  WORD_WIDTH  most recently added CH ID.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- found  out  1  qualified by done: packet source already in table.
- dropped  out  1  qualified by done: new source not stored, table full.
- chFull  out  1  level: knownCHCount == MAX_CH.

Function
REQ-007 SHALL implement states IDLE, READ, COMPARE, ADD, UPDATE, CHSCAN, CHADD, DONE.
REQ-008 In IDLE with en=1 SHALL latch all f* inputs and packetType, clear index n to 0, and go to READ if neighborCount>0, else to ADD; en outside IDLE SHALL be ignored.
REQ-009 READ SHALL drive rd_addr=n and go to COMPARE.
REQ-010 COMPARE SHALL go to UPDATE if mSourceID==latched fSourceID; otherwise it SHALL increment n and go to READ if n+1<neighborCount, else to ADD.
REQ-011 UPDATE SHALL pulse wr_en for one cycle with wr_addr=n and node* = latched fields, set found=1, and leave neighborCount unchanged.
REQ-012 ADD with neighborCount<MAX_NEIGHBORS SHALL pulse wr_en with wr_addr=neighborCount and node* = latched fields, and increment neighborCount.
REQ-013 ADD with neighborCount==MAX_NEIGHBORS SHALL not write and SHALL set dropped=1.
REQ-014 After UPDATE or ADD SHALL go to CHSCAN if latched packetType==CH_PKT, else to DONE.
REQ-015 CHSCAN SHALL compare the internal CH list one entry per cycle (index k from 0) against latched fSourceID; on a match it SHALL go to DONE; at k==knownCHCount it SHALL go to CHADD.
REQ-016 CHADD SHALL store fSourceID at entry knownCHCount, increment knownCHCount and set chID=fSourceID when chFull=0; when chFull=1 it SHALL make no change; it then goes to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, hold found/dropped valid in that cycle, and return to IDLE; en may be accepted in the following cycle.
REQ-018 wr_en SHALL never be high outside UPDATE/ADD and SHALL be high at most once per packet.
REQ-019 Latency from en to done SHALL be 2*(i+1)+2 cycles for a match at index i and 2*N+2 cycles for a miss with N=neighborCount, plus (CH entries scanned + 1) cycles, plus 1 for CHADD, when packetType==CH_PKT.
REQ-020 Counters SHALL saturate at MAX_NEIGHBORS and MAX_CH and SHALL never wrap.

Reset
REQ-021 nrst low SHALL asynchronously force IDLE and clear all outputs, neighborCount, knownCHCount, the CH list, n, k and the latched fields to 0.
REQ-022 Reset mid-operation SHALL abort the packet without a done pulse or further writes.

Verification
REQ-023 Empty table, en with fSourceID=0x0005 and packetType=0 -> wr_en at wr_addr=0, neighborCount=1, done at cycle 2, found=0.
REQ-024 Table holding IDs 3,5,9, en with fSourceID=0x0009 and fQValue=0x0040 -> writes at wr_addr=2 with nodeQValue=0x0040, found=1, count stays 3, done at cycle 8.
REQ-025 Table full (32 entries), unseen ID -> no wr_en, dropped=1, neighborCount=32.
REQ-026 Nine CH_PKT packets from distinct IDs -> knownCHCount=8, chFull=1, ninth ID not stored, chID = eighth ID; repeated CH ID -> count unchanged.
REQ-027 nrst pulsed during COMPARE -> outputs 0 immediately; no done pulse; next en is processed normally; en while busy -> ignored.
